imu_frame_unpacker: RTL and testbench

Producer side of the attitude filter path: takes the 14-byte MPU6050 burst read (registers 0x3B–0x48) from the I2C byte stream and unpacks the accelerometer and gyro words. It integrates the gyro rates into 24-bit angles, scales the accelerometer words into 24-bit small-angle estimates, and presents all five values with a one-cycle `cmp_filter_en` strobe. The complementary-filter stage consumes these outputs directly.

---
 rtl/imu_frame_unpacker_if.sv | 30 +++
 rtl/imu_frame_unpacker.sv | 191 +++++++++++++++++++
 tb/tb_imu_frame_unpacker.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imu_frame_unpacker_if.sv
// Byte-stream and result bundle between the I2C burst reader, the
// frame unpacker and the complementary-filter consumer.
interface imu_frame_unpacker_if;
    logic        frame_start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        gyro_zero;
    logic [23:0] cur_pitch_gyro;
    logic [23:0] cur_roll_gyro;
    logic [23:0] cur_yaw_gyro;
    logic [23:0] cur_pitch_acc;
    logic [23:0] cur_roll_acc;
    logic        cmp_filter_en;
    logic        frame_err;

    // Byte source / consumer side
    modport master (
        output frame_start, byte_valid, byte_data, gyro_zero,
        input  byte_ready, cur_pitch_gyro, cur_roll_gyro, cur_yaw_gyro,
               cur_pitch_acc, cur_roll_acc, cmp_filter_en, frame_err
    );

    // Unpacker side
    modport slave (
        input  frame_start, byte_valid, byte_data, gyro_zero,
        output byte_ready, cur_pitch_gyro, cur_roll_gyro, cur_yaw_gyro,
               cur_pitch_acc, cur_roll_acc, cmp_filter_en, frame_err
    );
endinterface

// File: rtl/imu_frame_unpacker.sv
// MPU6050 14-byte burst unpacker: captures AX/AY/GX/GY/GZ, integrates the
// gyro rates into 24-bit angles, scales the accel words into 24-bit
// small-angle estimates and strobes cmp_filter_en when all five update.
module imu_frame_unpacker #(
    parameter int GYRO_SHIFT = 7,
    parameter int ACC_SHIFT  = 4,
    parameter int TIMEOUT    = 50000
) (
    input logic             clk,
    input logic             rst,
    imu_frame_unpacker_if.slave bus
);
    localparam int             TW        = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]  TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [3:0]     LAST_BYTE = 4'd13;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        UPDATE
    } state_t;

    state_t          state_reg, state_next;
    logic [3:0]      byte_cnt_reg, byte_cnt_next;
    logic [TW-1:0]   tmo_cnt_reg, tmo_cnt_next;
    logic            frame_err_reg, frame_err_next;
    logic            cmp_reg;

    logic            ready;
    logic            accept;
    logic            capture;
    logic            do_update;

    logic [15:0]     word [5];
    logic [23:0]     angle [3];
    logic [23:0]     acc [2];

    genvar gi;

    assign ready     = (state_reg == COLLECT);
    assign accept    = bus.byte_valid && ready;
    // A byte arriving together with a restart belongs to the dead frame.
    assign capture   = accept && !bus.frame_start;
    assign do_update = (state_reg == UPDATE);

    // Frame sequencing state, byte index, inter-byte timeout and error pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            byte_cnt_reg  <= '0;
            tmo_cnt_reg   <= '0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            byte_cnt_reg  <= byte_cnt_next;
            tmo_cnt_reg   <= tmo_cnt_next;
            frame_err_reg <= frame_err_next;
        end
    end

    // Next-state logic; UPDATE lasts exactly one cycle, so a frame_start
    // seen there is honoured directly by going to COLLECT next.
    always_comb begin
        state_next     = state_reg;
        byte_cnt_next  = byte_cnt_reg;
        tmo_cnt_next   = tmo_cnt_reg;
        frame_err_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.frame_start) begin
                    state_next    = COLLECT;
                    byte_cnt_next = '0;
                    tmo_cnt_next  = '0;
                end
            end
            COLLECT: begin
                if (bus.frame_start) begin
                    frame_err_next = 1'b1;
                    byte_cnt_next  = '0;
                    tmo_cnt_next   = '0;
                end else if (accept) begin
                    tmo_cnt_next = '0;
                    if (byte_cnt_reg == LAST_BYTE) begin
                        state_next    = UPDATE;
                        byte_cnt_next = '0;
                    end else begin
                        byte_cnt_next = byte_cnt_reg + 4'd1;
                    end
                end else if (tmo_cnt_reg == TMO_LAST) begin
                    frame_err_next = 1'b1;
                    state_next     = IDLE;
                    byte_cnt_next  = '0;
                    tmo_cnt_next   = '0;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + TW'(1);
                end
            end
            UPDATE: begin
                if (bus.frame_start) begin
                    state_next    = COLLECT;
                    byte_cnt_next = '0;
                    tmo_cnt_next  = '0;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Word capture: index 0 AX, 1 AY, 2 GX, 3 GY, 4 GZ. AZ and temperature
    // (bytes 4..7) have no slot and fall through.
    generate
        for (gi = 0; gi < 5; gi++) begin : g_word
            localparam logic [3:0] HI_IDX = 4'((gi < 2) ? 2 * gi : 2 * gi + 4);
            logic [15:0] word_reg;

            // Big-endian assembly of one sensor word from the byte stream
            always_ff @(posedge clk) begin
                if (rst) begin
                    word_reg <= '0;
                end else if (capture && byte_cnt_reg == HI_IDX) begin
                    word_reg[15:8] <= bus.byte_data;
                end else if (capture && byte_cnt_reg == HI_IDX + 4'd1) begin
                    word_reg[7:0] <= bus.byte_data;
                end
            end

            assign word[gi] = word_reg;
        end
    endgenerate

    // Gyro integrators: floor-shifted rate added mod 2^24, zero has priority
    generate
        for (gi = 0; gi < 3; gi++) begin : g_gyro
            logic signed [23:0] rate;
            logic [23:0]        angle_reg;

            assign rate = $signed({{8{word[gi+2][15]}}, word[gi+2]}) >>> GYRO_SHIFT;

            // Integrate on UPDATE; gyro_zero wins over a coincident update
            always_ff @(posedge clk) begin
                if (rst || bus.gyro_zero) begin
                    angle_reg <= '0;
                end else if (do_update) begin
                    angle_reg <= angle_reg + rate;
                end
            end

            assign angle[gi] = angle_reg;
        end
    endgenerate

    // Accelerometer small-angle estimates: sign-extend then scale up
    generate
        for (gi = 0; gi < 2; gi++) begin : g_acc
            logic [23:0] acc_reg;

            // Load the scaled accel word on UPDATE, hold otherwise
            always_ff @(posedge clk) begin
                if (rst) begin
                    acc_reg <= '0;
                end else if (do_update) begin
                    acc_reg <= 24'($signed({{8{word[gi][15]}}, word[gi]}) <<< ACC_SHIFT);
                end
            end

            assign acc[gi] = acc_reg;
        end
    endgenerate

    // New-data strobe, high for the cycle after UPDATE
    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_reg <= 1'b0;
        end else begin
            cmp_reg <= do_update;
        end
    end

    assign bus.byte_ready     = ready;
    assign bus.cur_pitch_gyro = angle[0];
    assign bus.cur_roll_gyro  = angle[1];
    assign bus.cur_yaw_gyro   = angle[2];
    assign bus.cur_pitch_acc  = acc[0];
    assign bus.cur_roll_acc   = acc[1];
    assign bus.cmp_filter_en  = cmp_reg;
    assign bus.frame_err      = frame_err_reg;
endmodule

// File: tb/tb_imu_frame_unpacker.sv
// Bench for imu_frame_unpacker: two instances (GYRO_SHIFT 7 and 0) share
// one directed byte stream; a frame-level model predicts every output on
// every cycle, and literal values pin the model at key points.
module tb_imu_frame_unpacker;
    localparam int TMO = 24;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fs  = 1'b0;
    logic       bv  = 1'b0;
    logic       gz  = 1'b0;
    logic [7:0] bd  = 8'h00;
    int         cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    imu_frame_unpacker_if bus0 ();
    imu_frame_unpacker_if bus1 ();

    assign bus0.frame_start = fs;
    assign bus0.byte_valid  = bv;
    assign bus0.byte_data   = bd;
    assign bus0.gyro_zero   = gz;
    assign bus1.frame_start = fs;
    assign bus1.byte_valid  = bv;
    assign bus1.byte_data   = bd;
    assign bus1.gyro_zero   = gz;

    imu_frame_unpacker #(.GYRO_SHIFT(7), .ACC_SHIFT(4), .TIMEOUT(TMO)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    imu_frame_unpacker #(.GYRO_SHIFT(0), .ACC_SHIFT(4), .TIMEOUT(TMO)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    typedef logic [7:0] frame_t [14];
    typedef struct {
        int          cyc;
        bit          upd;
        bit          zero;
        bit          err;
        bit          rs;
        int          rdy;
        logic [15:0] ax, ay, gx, gy, gz;
    } ev_t;

    ev_t         evq[$];
    int          n_pass = 0;
    int          n_chk  = 0;
    bit          checking = 1'b0;

    // model state
    logic [23:0] e_pa = '0;
    logic [23:0] e_ra = '0;
    logic [23:0] e_g [2][3];
    bit          e_rdy = 1'b0;
    bit          m_upd, m_zero, m_err, m_rst;
    int          m_rdy;
    logic [15:0] m_ax, m_ay, m_gx, m_gy, m_gz;

    frame_t f1, f2, f3, f4, f5;

    function automatic frame_t mkf(logic [15:0] ax, logic [15:0] ay,
                                   logic [15:0] gx, logic [15:0] gy, logic [15:0] gzw);
        frame_t f;
        f[0]  = ax[15:8];  f[1]  = ax[7:0];
        f[2]  = ay[15:8];  f[3]  = ay[7:0];
        f[4]  = 8'h5A;     f[5]  = 8'hC3;
        f[6]  = 8'h0F;     f[7]  = 8'hF0;
        f[8]  = gx[15:8];  f[9]  = gx[7:0];
        f[10] = gy[15:8];  f[11] = gy[7:0];
        f[12] = gzw[15:8]; f[13] = gzw[7:0];
        return f;
    endfunction

    function automatic ev_t blank(int c);
        ev_t e;
        e.cyc = c; e.upd = 0; e.zero = 0; e.err = 0; e.rs = 0; e.rdy = -1;
        e.ax = '0; e.ay = '0; e.gx = '0; e.gy = '0; e.gz = '0;
        return e;
    endfunction

    // rate contribution: floor(value / 2^sh), wrapped to 24 bits
    function automatic logic [23:0] gstep(logic [15:0] w, int sh);
        int v;
        v = int'($signed(w));
        return 24'(v >>> sh);
    endfunction

    // accel estimate: value * 16, wrapped to 24 bits
    function automatic logic [23:0] ascale(logic [15:0] w);
        int v;
        v = int'($signed(w));
        return 24'(v * 16);
    endfunction

    task automatic chk(string nm, int inst, logic [23:0] act, logic [23:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", nm, inst, cyc, act, exp);
    endtask

    task automatic check_inst(int inst, logic rdy, logic cmp, logic err,
                              logic [23:0] pg, logic [23:0] rg, logic [23:0] yg,
                              logic [23:0] pa, logic [23:0] ra);
        chk("byte_ready",    inst, {23'd0, rdy}, {23'd0, e_rdy});
        chk("cmp_filter_en", inst, {23'd0, cmp}, {23'd0, m_upd});
        chk("frame_err",     inst, {23'd0, err}, {23'd0, m_err});
        chk("pitch_gyro",    inst, pg, e_g[inst][0]);
        chk("roll_gyro",     inst, rg, e_g[inst][1]);
        chk("yaw_gyro",      inst, yg, e_g[inst][2]);
        chk("pitch_acc",     inst, pa, e_pa);
        chk("roll_acc",      inst, ra, e_ra);
    endtask

    // Per-cycle compare: apply the events due at the edge just passed, then
    // check both instances against the model.
    always @(negedge clk) begin
        if (checking) begin
            m_upd = 0; m_zero = 0; m_err = 0; m_rst = 0; m_rdy = -1;
            m_ax = '0; m_ay = '0; m_gx = '0; m_gy = '0; m_gz = '0;
            for (int i = evq.size() - 1; i >= 0; i--) begin
                if (evq[i].cyc == cyc) begin
                    if (evq[i].upd) begin
                        m_upd = 1;
                        m_ax = evq[i].ax; m_ay = evq[i].ay;
                        m_gx = evq[i].gx; m_gy = evq[i].gy; m_gz = evq[i].gz;
                    end
                    if (evq[i].zero) m_zero = 1;
                    if (evq[i].err)  m_err = 1;
                    if (evq[i].rs)   m_rst = 1;
                    if (evq[i].rdy >= 0) m_rdy = evq[i].rdy;
                    evq.delete(i);
                end
            end
            if (m_rst) begin
                e_pa = '0; e_ra = '0; e_rdy = 0;
                m_upd = 0; m_err = 0;
                for (int n = 0; n < 2; n++)
                    for (int k = 0; k < 3; k++) e_g[n][k] = '0;
            end else begin
                if (m_upd) begin
                    e_pa = ascale(m_ax);
                    e_ra = ascale(m_ay);
                end
                for (int n = 0; n < 2; n++) begin
                    if (m_zero) begin
                        for (int k = 0; k < 3; k++) e_g[n][k] = '0;
                    end else if (m_upd) begin
                        e_g[n][0] = e_g[n][0] + gstep(m_gx, n == 0 ? 7 : 0);
                        e_g[n][1] = e_g[n][1] + gstep(m_gy, n == 0 ? 7 : 0);
                        e_g[n][2] = e_g[n][2] + gstep(m_gz, n == 0 ? 7 : 0);
                    end
                end
                if (m_rdy >= 0) e_rdy = m_rdy[0];
            end
            check_inst(0, bus0.byte_ready, bus0.cmp_filter_en, bus0.frame_err,
                       bus0.cur_pitch_gyro, bus0.cur_roll_gyro, bus0.cur_yaw_gyro,
                       bus0.cur_pitch_acc, bus0.cur_roll_acc);
            check_inst(1, bus1.byte_ready, bus1.cmp_filter_en, bus1.frame_err,
                       bus1.cur_pitch_gyro, bus1.cur_roll_gyro, bus1.cur_yaw_gyro,
                       bus1.cur_pitch_acc, bus1.cur_roll_acc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic start_frame(bit exp_err);
        ev_t e;
        fs = 1'b1;
        e = blank(cyc + 1);
        e.rdy = 1;
        e.err = exp_err;
        evq.push_back(e);
        tick();
        fs = 1'b0;
    endtask

    task automatic send_bytes(frame_t f, int lo, int hi);
        ev_t e;
        for (int i = lo; i <= hi; i++) begin
            bv = 1'b1;
            bd = f[i];
            tick();
            if (i == 13) begin
                e = blank(cyc);
                e.rdy = 0;
                evq.push_back(e);
                e = blank(cyc + 1);
                e.upd = 1;
                e.ax = {f[0], f[1]};   e.ay = {f[2], f[3]};
                e.gx = {f[8], f[9]};   e.gy = {f[10], f[11]};
                e.gz = {f[12], f[13]};
                evq.push_back(e);
            end
        end
        bv = 1'b0;
        bd = 8'h00;
    endtask

    task automatic send_frame(frame_t f);
        start_frame(0);
        send_bytes(f, 0, 13);
    endtask

    task automatic pulse_zero();
        ev_t e;
        gz = 1'b1;
        e = blank(cyc + 1);
        e.zero = 1;
        evq.push_back(e);
        tick();
        gz = 1'b0;
    endtask

    task automatic do_reset(int n);
        ev_t e;
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            e = blank(cyc + 1);
            e.rs = 1;
            evq.push_back(e);
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        ev_t e;
        for (int n = 0; n < 2; n++)
            for (int k = 0; k < 3; k++) e_g[n][k] = '0;
        f1 = mkf(16'h0100, 16'hFF00, 16'h0080, 16'hFF80, 16'h1000);
        f2 = mkf(16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000);
        f3 = mkf(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h7FFF);
        f4 = mkf(16'h0ABC, 16'h8000, 16'h0100, 16'h0000, 16'h0000);
        f5 = mkf(16'h0010, 16'h0020, 16'h0080, 16'h0080, 16'h0080);

        // power-on reset; model starts at all-zero
        rst = 1'b1;
        idle(2);
        checking = 1'b1;
        tick();
        rst = 1'b0;
        idle(2);

        // basic frame, then a repeat
        send_frame(f1);
        idle(3);
        chk("lit_pitch_acc", 0, bus0.cur_pitch_acc, 24'h001000);
        chk("lit_roll_acc", 0, bus0.cur_roll_acc, 24'hFFF000);
        chk("lit_pitch_gyro", 0, bus0.cur_pitch_gyro, 24'h000001);
        chk("lit_roll_gyro", 0, bus0.cur_roll_gyro, 24'hFFFFFF);
        chk("lit_yaw_gyro", 0, bus0.cur_yaw_gyro, 24'h000020);
        send_frame(f1);
        idle(3);
        chk("lit_pitch_gyro2", 0, bus0.cur_pitch_gyro, 24'h000002);
        chk("lit_roll_gyro2", 0, bus0.cur_roll_gyro, 24'hFFFFFE);
        chk("lit_yaw_gyro2", 0, bus0.cur_yaw_gyro, 24'h000040);

        // floor of a -1 rate
        send_frame(f2);
        idle(2);
        chk("lit_floor1", 0, bus0.cur_pitch_gyro, 24'h000001);
        send_frame(f2);
        idle(2);
        chk("lit_floor2", 0, bus0.cur_pitch_gyro, 24'h000000);

        // reset in the middle of a frame
        start_frame(0);
        send_bytes(f1, 0, 4);
        do_reset(3);
        idle(2);
        chk("lit_rst_roll_acc", 0, bus0.cur_roll_acc, 24'h000000);
        chk("lit_rst_yaw", 1, bus1.cur_yaw_gyro, 24'h000000);
        chk("lit_rst_ready", 0, {23'd0, bus0.byte_ready}, 24'h000000);

        // wrap: back-to-back frames, every restart lands in UPDATE
        for (int j = 0; j < 256; j++) send_frame(f3);
        idle(3);
        chk("lit_yaw_256", 1, bus1.cur_yaw_gyro, 24'h7FFF00);
        send_frame(f3);
        idle(3);
        chk("lit_yaw_257", 1, bus1.cur_yaw_gyro, 24'h807EFF);
        chk("lit_yaw_257_s7", 0, bus0.cur_yaw_gyro, 24'h00FFFF);

        // timeout after 6 bytes, then a normal frame
        start_frame(0);
        send_bytes(f1, 0, 5);
        e = blank(cyc + TMO);
        e.err = 1;
        e.rdy = 0;
        evq.push_back(e);
        idle(TMO + 3);
        chk("lit_tmo_hold", 1, bus1.cur_yaw_gyro, 24'h807EFF);
        send_frame(f1);
        idle(3);
        chk("lit_after_tmo", 0, bus0.cur_yaw_gyro, 24'h01001F);
        chk("lit_after_tmo_acc", 0, bus0.cur_pitch_acc, 24'h001000);

        // restart after byte 9, with a byte offered in the restart cycle
        start_frame(0);
        send_bytes(f1, 0, 8);
        fs = 1'b1;
        bv = 1'b1;
        bd = 8'hEE;
        e = blank(cyc + 1);
        e.err = 1;
        evq.push_back(e);
        tick();
        fs = 1'b0;
        bv = 1'b0;
        send_bytes(f4, 0, 13);
        idle(3);
        chk("lit_restart_pa", 0, bus0.cur_pitch_acc, 24'h00ABC0);
        chk("lit_restart_ra", 0, bus0.cur_roll_acc, 24'hF80000);

        // frame_start during UPDATE
        send_frame(f1);
        start_frame(0);
        chk("lit_pend_ready", 0, {23'd0, bus0.byte_ready}, 24'h000001);
        chk("lit_pend_strobe", 0, {23'd0, bus0.cmp_filter_en}, 24'h000001);
        send_bytes(f1, 0, 13);
        idle(3);

        // gyro_zero coincident with UPDATE
        send_frame(f5);
        pulse_zero();
        idle(2);
        chk("lit_zero_pg", 0, bus0.cur_pitch_gyro, 24'h000000);
        chk("lit_zero_yg", 1, bus1.cur_yaw_gyro, 24'h000000);
        chk("lit_zero_pa", 0, bus0.cur_pitch_acc, 24'h000100);
        chk("lit_zero_ra", 0, bus0.cur_roll_acc, 24'h000200);

        // gyro_zero while idle
        send_frame(f1);
        idle(2);
        pulse_zero();
        idle(2);
        chk("lit_idle_zero", 0, bus0.cur_yaw_gyro, 24'h000000);

        checking = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
